// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage ALU: single-cycle arith/logic, iterative 1-bit-per-cycle shifts
// Operands are taken on an in_valid/in_ready handshake; the result is held in DONE until out_ready.
module alu_exec_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUcontrol,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   shamt;
  logic             in_shift;
  logic             in_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] work_nx;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_v;

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;
  assign shamt    = src_b[SHW-1:0];
  assign in_shift = ALUcontrol[2] && (ALUcontrol[1:0] != 2'b01);
  assign in_arith = (ALUcontrol == 3'b000) || (ALUcontrol == 3'b001) || (ALUcontrol == 3'b101);

  // sub and slt share the A + ~B + 1 adder path
  always_comb begin
    b_eff = (ALUcontrol == 3'b000) ? src_b : ~src_b;
    sum   = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (ALUcontrol != 3'b000)};
    ovf   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  end

  always_comb begin
    work_nx = work;
    case (op)
      3'b100:  work_nx = {work[WIDTH-2:0], 1'b0};
      3'b110:  work_nx = {1'b0, work[WIDTH-1:1]};
      default: work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  // value written to the result register, whichever state writes it
  always_comb begin
    fin_res = src_a;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    if (state == SHIFT) begin
      fin_res = work_nx;
    end else if (!in_shift) begin
      case (ALUcontrol)
        3'b010:  fin_res = src_a & src_b;
        3'b011:  fin_res = src_a | src_b;
        3'b101:  fin_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
        default: fin_res = sum[WIDTH-1:0];
      endcase
      fin_c = in_arith && sum[WIDTH];
      fin_v = in_arith && ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= 3'b000;
      work      <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op <= ALUcontrol;
            if (in_shift && (shamt != '0)) begin
              work  <= src_a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result    <= fin_res;
              zero      <= (fin_res == '0);
              negative  <= fin_res[WIDTH-1];
              carry     <= fin_c;
              overflow  <= fin_v;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= work_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            negative  <= fin_res[WIDTH-1];
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - randomized self-checking bench for alu_exec_seq against an arithmetic model
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ALUcontrol = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, negative, carry, overflow, busy;

  int total = 0;
  int bad   = 0;

  alu_exec_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcontrol(ALUcontrol), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v, output int lat);
    logic [32:0] s;
    int sh;
    sh  = int'(b[4:0]);
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001, 3'b101: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
        if (op == 3'b101) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a << sh;
      3'b110: r = a >> sh;
      default: r = 32'($signed(a) >>> sh);
    endcase
    if (op[2] && op != 3'b101 && sh != 0) lat = sh + 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [31:0] er;
    logic        ec, ev;
    int          elat, lat, n;
    model(op, a, b, er, ec, ev, elat);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before", 32'(in_ready), 32'd1);
    ALUcontrol = op;
    src_a      = a;
    src_b      = b;
    in_valid   = 1'b1;
    lat        = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) begin
        chk("busy_wait", {30'd0, in_ready, busy}, 32'b01);
        in_valid   = 1'($urandom_range(0, 1));
        ALUcontrol = 3'($urandom);
        src_a      = $urandom;
        src_b      = $urandom;
      end
    end while (!out_valid && lat < 70);
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(elat));
    chk("result", result, er);
    chk("flags", {28'd0, zero, negative, carry, overflow}, {28'd0, er == 32'd0, er[31], ec, ev});
    repeat (bp) begin
      @(negedge clk);
      chk("hold_result", result, er);
      chk("hold_flags", {28'd0, zero, negative, carry, overflow}, {28'd0, er == 32'd0, er[31], ec, ev});
      chk("hold_ctl", {29'd0, out_valid, in_ready, busy}, 32'b101);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff", {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        seen;

    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_ctl", {25'd0, out_valid, zero, negative, carry, overflow, in_ready, busy}, 32'b0000010);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'h7FFFFFFF, 32'h00000001, 0);
    run_op(3'b001, 32'h12345678, 32'h12345678, 0);
    run_op(3'b101, 32'hFFFFFFFF, 32'h00000001, 0);
    run_op(3'b101, 32'h00000001, 32'hFFFFFFFF, 0);
    run_op(3'b111, 32'h80000000, 32'h00000004, 0);
    run_op(3'b100, 32'h000000A5, 32'h00000000, 0);
    run_op(3'b110, 32'h80000001, 32'h0000001F, 1);
    run_op(3'b011, 32'hF0F0F0F0, 32'h0F0F0F0F, 10);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: b[4:0] = 5'd0;
        2: a = 32'h80000000;
        default: ;
      endcase
      run_op(op, a, b, int'($urandom_range(0, 3)));
    end

    // asynchronous reset in the middle of a long shift
    while (!in_ready) @(negedge clk);
    ALUcontrol = 3'b100;
    src_a      = 32'h0000FFFF;
    src_b      = 32'd20;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_ctl", {25'd0, out_valid, zero, negative, carry, overflow, in_ready, busy}, 32'b0000010);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_output", 32'(seen), 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Execute-stage ALU that consumes the 3-bit ALUcontrol code produced by the ALU control decoder.
- Registers the operands on a valid/ready handshake and computes arithmetic/logic ops in one cycle and shifts iteratively, one bit per cycle.
- Returns the result and flags on a registered valid/ready output.
- Sits between decode/register-read and writeback in the multi-cycle core variant.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  high when the block can accept a request.
- ALUcontrol  input  3  op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 100 sll, 110 srl, 111 sra.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; shift amount = src_b[SHW-1:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- carry  output  1  add: carry-out; sub/slt: carry-out of A + ~B + 1 (1 = no borrow); else 0.
- overflow  output  1  signed overflow for add/sub/slt; else 0.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock; reset is asynchronous and active-low.
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE), combinational; busy = !in_ready.
- Reset (any state, including mid-shift):
  - state -> IDLE, shift counter -> 0.
  - result, zero, negative, carry, overflow, out_valid -> 0.
  - Any in-flight op is discarded; nothing is emitted after reset releases.
- IDLE:
  - Accept on in_valid && in_ready; latch ALUcontrol, src_a, src_b.
  - add/sub/and/or/slt: result and flags registered at the accept edge; DONE next cycle with out_valid = 1. Latency 1 cycle.
  - Shift op with shamt != 0: load the working register with src_a and counter = shamt, go to SHIFT.
  - Shift op with shamt == 0: result = src_a, go straight to DONE. Latency 1.
- SHIFT:
  - Each cycle shift the working register by 1 (sll: zero fill; srl: zero fill; sra: MSB replicated) and decrement the counter.
  - When the counter reaches 1, the final shift is written to result and state -> DONE.
  - Total latency from accept to out_valid = shamt + 1 cycles; shamt 31 -> 32 cycles.
  - Inputs are ignored while in SHIFT; in_ready = 0.
- DONE:
  - out_valid = 1; result and flags are held stable while out_ready = 0 (unbounded backpressure).
  - On out_valid && out_ready -> IDLE; out_valid drops next cycle.
  - No accept in the same cycle as result handoff; minimum issue interval is 2 cycles.
- Arithmetic:
  - Everything modulo 2^WIDTH; sub = A + ~B + 1.
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' = B for add and ~B for sub/slt.
  - slt result = {0..., sum[MSB] ^ overflow}; its carry and overflow come from the subtraction.
  - Logic and shift ops force carry = overflow = 0.
  - zero and negative are always derived from the final registered result.
- Op code 100/110/111 are shifts. No illegal codes exist; all 8 codes are defined.

Test Plan:
- add A=0x7FFFFFFF, B=0x00000001 -> out_valid 1 cycle after accept; result 0x80000000, negative=1, overflow=1, carry=0, zero=0.
- sub A=B=0x12345678 -> result 0, zero=1, carry=1, overflow=0.
- slt A=0xFFFFFFFF (-1), B=1 -> result 1. slt A=1, B=0xFFFFFFFF -> result 0.
- sra A=0x80000000, shamt 4 -> out_valid exactly 5 cycles after accept; result 0xF8000000; in_ready=0 and busy=1 throughout. sll shamt 0 with A=0xA5 -> result 0xA5 after 1 cycle.
- Backpressure: out_ready held 0 for 10 cycles in DONE -> result and flags unchanged and in_ready=0; drop out_ready to 0 again after the handshake -> IDLE, in_ready=1 next cycle.
- Assert rst mid-way through an sll of shamt 20 -> all outputs 0 and in_ready=1 immediately; after release, a new add 3+4 returns 7 with no stale output.
